// File: rtl/lc_readout_pkg.sv
// -----------------------------------------------------------------------------
// lc_readout_pkg
// Shared definitions for the local-coincidence readout arbiter:
//   - per-channel state encodings (IDLE / PENDING / HOLDOFF)
//   - default timestamp width
//   - saturation ceiling of the dropped-edge counter
// -----------------------------------------------------------------------------
package lc_readout_pkg;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_IDLE    = 2'd0;
    localparam chan_state_t ST_PENDING = 2'd1;
    localparam chan_state_t ST_HOLDOFF = 2'd2;

    localparam int          LC_TS_WIDTH  = 48;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/lc_chan_holdoff.sv
// -----------------------------------------------------------------------------
// lc_chan_holdoff
// One trigger channel: rising-edge detect on the coincidence level, timestamp
// capture, wait-for-grant, then a programmable holdoff before re-arming.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       when low, edges are neither captured nor counted as drops
//   holdoff      holdoff length, loaded into hcnt when the grant arrives
//   coinc        coincidence level for this channel
//   ltc          local time counter, latched into ts on a captured edge
//   grant        arbiter has loaded this channel into the output register
//   pending      channel is waiting for a grant
//   drop         an enabled edge arrived while the channel was busy
//   ts           timestamp of the captured edge
// -----------------------------------------------------------------------------
module lc_chan_holdoff
    import lc_readout_pkg::*;
#(
    parameter int TS_WIDTH = LC_TS_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [15:0]         holdoff,
    input  logic                coinc,
    input  logic [TS_WIDTH-1:0] ltc,
    input  logic                grant,
    output logic                pending,
    output logic                drop,
    output logic [TS_WIDTH-1:0] ts
);

    logic        prev;
    logic        edge_det;
    chan_state_t state;
    logic [15:0] hcnt;

    // prev resets low, so a level already high at reset release is an edge.
    assign edge_det = coinc & ~prev;
    assign pending  = (state == ST_PENDING);
    // A grant and an edge in the same cycle see PENDING here, so the edge drops.
    assign drop     = edge_det & enable & (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            state <= ST_IDLE;
            hcnt  <= '0;
        end else begin
            prev <= coinc;
            case (state)
                ST_IDLE: begin
                    if (edge_det && enable) state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (grant) begin
                        state <= ST_HOLDOFF;
                        hcnt  <= holdoff;
                    end
                end
                ST_HOLDOFF: begin
                    // hcnt == 0 is itself a holdoff cycle: holdoff+1 cycles total.
                    if (hcnt == 16'd0) state <= ST_IDLE;
                    else               hcnt  <= hcnt - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Timestamp is only consumed while PENDING, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && edge_det && enable) ts <= ltc;
    end

endmodule

// File: rtl/lc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// lc_readout_arbiter
// Converts per-channel local-coincidence levels into a serialized stream of
// readout requests (channel index + timestamp) through a round-robin arbiter
// and a registered valid/ready output. Edges lost to per-channel holdoff are
// counted in a saturating drop counter.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         gate for new edge capture
//   holdoff        per-grant holdoff length (cycles)
//   local_coinc    per-channel coincidence levels
//   ltc            free-running local time counter
//   drop_clr       replace drop_cnt with this cycle's drop count
//   rd_req_*       request output (valid/ready, channel, timestamp)
//   pending        per-channel pending flags
//   drop_cnt       saturating dropped-edge count
// -----------------------------------------------------------------------------
module lc_readout_arbiter
    import lc_readout_pkg::*;
#(
    parameter int N_CHANNELS   = 24,
    parameter int CH_IDX_WIDTH = 5,
    parameter int TS_WIDTH     = LC_TS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [15:0]             holdoff,
    input  logic [N_CHANNELS-1:0]   local_coinc,
    input  logic [TS_WIDTH-1:0]     ltc,
    input  logic                    drop_clr,
    output logic                    rd_req_valid,
    input  logic                    rd_req_ready,
    output logic [CH_IDX_WIDTH-1:0] rd_req_chan,
    output logic [TS_WIDTH-1:0]     rd_req_ts,
    output logic [N_CHANNELS-1:0]   pending,
    output logic [15:0]             drop_cnt
);

    localparam int CNT_W = CH_IDX_WIDTH + 1;

    logic [N_CHANNELS-1:0]   drop_w;
    logic [N_CHANNELS-1:0]   grant_w;
    logic [TS_WIDTH-1:0]     ch_ts [N_CHANNELS];
    logic [CH_IDX_WIDTH-1:0] last;
    logic                    load;
    logic                    found;
    logic [CH_IDX_WIDTH-1:0] sel_chan;
    logic [TS_WIDTH-1:0]     sel_ts;
    logic [CNT_W-1:0]        cycle_drops;
    int                      scan_idx;

    function automatic logic [15:0] drop_sat_add(input logic [15:0]      acc,
                                                 input logic [CNT_W-1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(inc);
        return sum[16] ? DROP_CNT_MAX : sum[15:0];
    endfunction

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        lc_chan_holdoff #(
            .TS_WIDTH (TS_WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .holdoff (holdoff),
            .coinc   (local_coinc[g]),
            .ltc     (ltc),
            .grant   (grant_w[g]),
            .pending (pending[g]),
            .drop    (drop_w[g]),
            .ts      (ch_ts[g])
        );
    end

    assign load = ~rd_req_valid | rd_req_ready;

    // Circular scan starting just above the last granted channel.
    always_comb begin
        found    = 1'b0;
        sel_chan = '0;
        sel_ts   = '0;
        grant_w  = '0;
        scan_idx = 0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            scan_idx = int'(last) + 1 + k;
            if (scan_idx >= N_CHANNELS) scan_idx = scan_idx - N_CHANNELS;
            if (!found && pending[scan_idx]) begin
                found    = 1'b1;
                sel_chan = CH_IDX_WIDTH'(scan_idx);
                sel_ts   = ch_ts[scan_idx];
            end
        end
        if (load && found) grant_w[sel_chan] = 1'b1;
    end

    always_comb begin
        cycle_drops = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            cycle_drops = cycle_drops + CNT_W'(drop_w[i]);
        end
    end

    // Output register stage: loading a pending channel is its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_valid <= 1'b0;
            rd_req_chan  <= '0;
            rd_req_ts    <= '0;
            last         <= CH_IDX_WIDTH'(N_CHANNELS - 1);
            drop_cnt     <= '0;
        end else begin
            if (load) begin
                rd_req_valid <= found;
                if (found) begin
                    rd_req_chan <= sel_chan;
                    rd_req_ts   <= sel_ts;
                    last        <= sel_chan;
                end
            end
            // Clear still accounts for drops occurring in the same cycle.
            drop_cnt <= drop_clr ? 16'(cycle_drops) : drop_sat_add(drop_cnt, cycle_drops);
        end
    end

endmodule

// File: tb/tb_lc_readout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lc_readout_arbiter
// Directed, self-checking bench for lc_readout_arbiter. Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_lc_readout_arbiter;

    localparam int N  = 24;
    localparam int IW = 5;
    localparam int TW = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   holdoff;
    logic [N-1:0]  local_coinc;
    logic [TW-1:0] ltc;
    logic          drop_clr;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [IW-1:0] rd_req_chan;
    logic [TW-1:0] rd_req_ts;
    logic [N-1:0]  pending;
    logic [15:0]   drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lc_readout_arbiter #(
        .N_CHANNELS   (N),
        .CH_IDX_WIDTH (IW),
        .TS_WIDTH     (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .holdoff      (holdoff),
        .local_coinc  (local_coinc),
        .ltc          (ltc),
        .drop_clr     (drop_clr),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_chan  (rd_req_chan),
        .rd_req_ts    (rd_req_ts),
        .pending      (pending),
        .drop_cnt     (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
        ltc = ltc + 1;
    endtask

    task automatic settle();
        local_coinc  = '0;
        rd_req_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1; enable = 1'b1; holdoff = 16'd0; local_coinc = '0;
        ltc = '0; drop_clr = 1'b0; rd_req_ready = 1'b1;
        #2 rst_n = 1'b0;
        step(); step();
        n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", rd_req_valid); end
        n_cmp++; if (rd_req_chan !== 5'd0) begin n_bad++; $display("FAIL reset_chan: got %0d want 0", rd_req_chan); end
        n_cmp++; if (rd_req_ts !== 48'd0) begin n_bad++; $display("FAIL reset_ts: got %0d want 0", rd_req_ts); end
        n_cmp++; if (pending !== 24'd0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        rst_n = 1'b1;
        step(); step();
        n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid: got %0b want 0", rd_req_valid); end
    endtask

    task automatic test_multi();
        int          exp_ch[3] = '{0, 3, 23};
        logic [TW-1:0] exp_ts;
        holdoff = 16'd3;
        rd_req_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            ltc = 48'(2000 + 1000 * r);
            exp_ts = ltc;
            local_coinc = 24'h800009;
            step();
            n_cmp++; if (pending !== 24'h800009) begin n_bad++; $display("FAIL multi_pending r%0d: got %h want 800009", r, pending); end
            for (int k = 0; k < 3; k++) begin
                step();
                n_cmp++;
                if (rd_req_valid !== 1'b1 || rd_req_chan !== IW'(exp_ch[k]) || rd_req_ts !== exp_ts) begin
                    n_bad++;
                    $display("FAIL multi_order r%0d k%0d: got v=%0b ch=%0d ts=%0d want v=1 ch=%0d ts=%0d",
                             r, k, rd_req_valid, rd_req_chan, rd_req_ts, exp_ch[k], exp_ts);
                end
            end
            step();
            n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL multi_idle r%0d: got v=%0b want 0", r, rd_req_valid); end
            local_coinc = '0;
            repeat (8) step();
        end
    endtask

    task automatic test_single();
        holdoff = 16'd2;
        ltc = 48'd1000;
        local_coinc = 24'd1 << 5;
        step();
        n_cmp++; if (pending !== (24'd1 << 5) || rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL single_capture: got pend=%h v=%0b want pend=000020 v=0", pending, rd_req_valid); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd5 || rd_req_ts !== 48'd1000) begin n_bad++; $display("FAIL single_req: got v=%0b ch=%0d ts=%0d want v=1 ch=5 ts=1000", rd_req_valid, rd_req_chan, rd_req_ts); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle: got v=%0b want 0", rd_req_valid); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL single_drop: got %0d want 0", drop_cnt); end
        settle();
    endtask

    task automatic test_backpressure();
        holdoff = 16'd2;
        rd_req_ready = 1'b1;
        ltc = 48'd4000;
        local_coinc = 24'd1 << 2;
        step(); step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd2 || rd_req_ts !== 48'd4000) begin n_bad++; $display("FAIL bp_first: got v=%0b ch=%0d ts=%0d want v=1 ch=2 ts=4000", rd_req_valid, rd_req_chan, rd_req_ts); end
        rd_req_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                local_coinc = local_coinc | (24'd1 << 7);
                ltc = 48'd4100;
            end
            step();
            n_cmp++;
            if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd2 || rd_req_ts !== 48'd4000) begin
                n_bad++;
                $display("FAIL bp_hold c%0d: got v=%0b ch=%0d ts=%0d want v=1 ch=2 ts=4000", i, rd_req_valid, rd_req_chan, rd_req_ts);
            end
        end
        n_cmp++; if (pending !== (24'd1 << 7)) begin n_bad++; $display("FAIL bp_pending: got %h want 000080", pending); end
        rd_req_ready = 1'b1;
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd7 || rd_req_ts !== 48'd4100) begin n_bad++; $display("FAIL bp_next: got v=%0b ch=%0d ts=%0d want v=1 ch=7 ts=4100", rd_req_valid, rd_req_chan, rd_req_ts); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got v=%0b want 0", rd_req_valid); end
        settle();
    endtask

    task automatic test_holdoff4();
        holdoff = 16'd4;
        ltc = 48'd5000;
        local_coinc = 24'd1 << 1;
        step(); step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd1 || rd_req_ts !== 48'd5000) begin n_bad++; $display("FAIL ho4_grant: got v=%0b ch=%0d ts=%0d want v=1 ch=1 ts=5000", rd_req_valid, rd_req_chan, rd_req_ts); end
        local_coinc = '0;
        step(); step(); step();
        local_coinc = 24'd1 << 1;
        step();
        n_cmp++; if (drop_cnt !== 16'd1 || pending !== 24'd0) begin n_bad++; $display("FAIL ho4_drop: got cnt=%0d pend=%h want cnt=1 pend=0", drop_cnt, pending); end
        local_coinc = '0;
        step();
        local_coinc = 24'd1 << 1;
        ltc = 48'd5500;
        step();
        n_cmp++; if (pending !== (24'd1 << 1) || drop_cnt !== 16'd1) begin n_bad++; $display("FAIL ho4_capture: got pend=%h cnt=%0d want pend=000002 cnt=1", pending, drop_cnt); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd1 || rd_req_ts !== 48'd5500) begin n_bad++; $display("FAIL ho4_regrant: got v=%0b ch=%0d ts=%0d want v=1 ch=1 ts=5500", rd_req_valid, rd_req_chan, rd_req_ts); end
        settle();
    endtask

    task automatic test_holdoff0();
        holdoff = 16'd0;
        ltc = 48'd6000;
        local_coinc = 24'd1 << 4;
        step();
        local_coinc = '0;
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd4 || rd_req_ts !== 48'd6000) begin n_bad++; $display("FAIL ho0_grant: got v=%0b ch=%0d ts=%0d want v=1 ch=4 ts=6000", rd_req_valid, rd_req_chan, rd_req_ts); end
        local_coinc = 24'd1 << 4;
        step();
        n_cmp++; if (drop_cnt !== 16'd2 || pending !== 24'd0) begin n_bad++; $display("FAIL ho0_drop_g1: got cnt=%0d pend=%h want cnt=2 pend=0", drop_cnt, pending); end
        local_coinc = '0;
        step();
        local_coinc = 24'd1 << 4;
        ltc = 48'd6100;
        step();
        local_coinc = '0;
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd4 || rd_req_ts !== 48'd6100) begin n_bad++; $display("FAIL ho0_grant2: got v=%0b ch=%0d ts=%0d want v=1 ch=4 ts=6100", rd_req_valid, rd_req_chan, rd_req_ts); end
        step();
        local_coinc = 24'd1 << 4;
        ltc = 48'd6200;
        step();
        n_cmp++; if (pending !== (24'd1 << 4) || drop_cnt !== 16'd2) begin n_bad++; $display("FAIL ho0_capture_g2: got pend=%h cnt=%0d want pend=000010 cnt=2", pending, drop_cnt); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd4 || rd_req_ts !== 48'd6200) begin n_bad++; $display("FAIL ho0_grant3: got v=%0b ch=%0d ts=%0d want v=1 ch=4 ts=6200", rd_req_valid, rd_req_chan, rd_req_ts); end
        settle();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        local_coinc = (24'd1 << 9) | (24'd1 << 10);
        step(); step(); step();
        n_cmp++; if (rd_req_valid !== 1'b0 || pending !== 24'd0) begin n_bad++; $display("FAIL en_off_req: got v=%0b pend=%h want v=0 pend=0", rd_req_valid, pending); end
        n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL en_off_drop: got %0d want 2", drop_cnt); end
        local_coinc = '0;
        enable = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        holdoff = 16'hFFFF;
        rd_req_ready = 1'b0;
        enable = 1'b1;
        local_coinc = '0;
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL sat_clr0: got %0d want 0", drop_cnt); end
        local_coinc = '1;
        step(); step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd5) begin n_bad++; $display("FAIL sat_grant: got v=%0b ch=%0d want v=1 ch=5", rd_req_valid, rd_req_chan); end
        repeat (2730) begin
            local_coinc = '0;
            step();
            local_coinc = '1;
            step();
        end
        n_cmp++; if (drop_cnt !== 16'd65520) begin n_bad++; $display("FAIL sat_near: got %0d want 65520", drop_cnt); end
        local_coinc = '0;
        step();
        local_coinc = '1;
        step();
        n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_ceiling: got %h want ffff", drop_cnt); end
        local_coinc = '0;
        drop_clr = 1'b1;
        step();
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL sat_clr: got %0d want 0", drop_cnt); end
        local_coinc = '1;
        step();
        n_cmp++; if (drop_cnt !== 16'd24) begin n_bad++; $display("FAIL sat_clr_with_drops: got %0d want 24", drop_cnt); end
        drop_clr = 1'b0;
        enable = 1'b0;
        local_coinc = '0;
        step();
        local_coinc = '1;
        step();
        n_cmp++; if (drop_cnt !== 16'd24) begin n_bad++; $display("FAIL sat_disabled_edges: got %0d want 24", drop_cnt); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        local_coinc = 24'd1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (rd_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b want 0", rd_req_valid); end
        n_cmp++; if (rd_req_chan !== 5'd0 || rd_req_ts !== 48'd0) begin n_bad++; $display("FAIL mid_rst_data: got ch=%0d ts=%0d want 0/0", rd_req_chan, rd_req_ts); end
        n_cmp++; if (pending !== 24'd0) begin n_bad++; $display("FAIL mid_rst_pending: got %h want 0", pending); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_drop: got %0d want 0", drop_cnt); end
        step();
        rst_n = 1'b1;
        rd_req_ready = 1'b1;
        ltc = 48'd7000;
        step();
        n_cmp++; if (pending !== 24'd1) begin n_bad++; $display("FAIL mid_rst_level_edge: got pend=%h want 000001", pending); end
        step();
        n_cmp++; if (rd_req_valid !== 1'b1 || rd_req_chan !== 5'd0 || rd_req_ts !== 48'd7000) begin n_bad++; $display("FAIL mid_rst_first_prio: got v=%0b ch=%0d ts=%0d want v=1 ch=0 ts=7000", rd_req_valid, rd_req_chan, rd_req_ts); end
    endtask

    initial begin
        test_reset();
        test_multi();
        test_single();
        test_backpressure();
        test_holdoff4();
        test_holdoff0();
        test_enable();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, wanted finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/lc_readout_arbiter.md
# lc_readout_arbiter

Sits directly downstream of the local-coincidence stage and turns its per-channel `local_coinc` levels into a serialized stream of readout requests. Each request carries a channel index and a timestamp. Each channel captures the rising edge of its coincidence flag, then waits in a pending state. A round-robin arbiter loads pending channels one at a time into a registered valid/ready output. After a channel is granted, a programmable per-channel holdoff suppresses retriggering, and edges lost to that suppression are counted.

## Interface
- `N_CHANNELS`, 24, number of trigger channels
- `CH_IDX_WIDTH`, 5, width of channel index; must satisfy 2^CH_IDX_WIDTH >= N_CHANNELS
- `TS_WIDTH`, 48, width of local time counter
- `clk` input 1: single clock for the whole block
- `rst_n` input 1: asynchronous active-low reset
- `enable` input 1: when low, no new edges are captured
- `holdoff` input 16: holdoff length in clock cycles, sampled at grant
- `local_coinc` input N_CHANNELS: per-channel coincidence level from the upstream stage
- `ltc` input TS_WIDTH: free-running local time counter
- `drop_clr` input 1: synchronous clear of `drop_cnt`
- `rd_req_valid` output 1: request present
- `rd_req_ready` input 1: consumer accepts the request
- `rd_req_chan` output CH_IDX_WIDTH: granted channel index
- `rd_req_ts` output TS_WIDTH: `ltc` latched at that channel's edge
- `pending` output N_CHANNELS: per-channel pending flags
- `drop_cnt` output 16: count of dropped edges, saturating

## Operation
- Edge detect per channel: `edge[i] = local_coinc[i] & ~prev[i]`. The `prev` register resets to 0, so a level already high when reset releases counts as an edge.
- Each channel runs its own state machine with states IDLE, PENDING and HOLDOFF.
  - IDLE: `edge & enable` moves to PENDING and latches `ts[i] <= ltc`.
  - PENDING: wait for grant. On grant, move to HOLDOFF and load `hcnt <= holdoff`.
  - HOLDOFF: if `hcnt == 0`, go to IDLE; otherwise `hcnt <= hcnt - 1`. A channel therefore stays in HOLDOFF for holdoff+1 cycles.
- Drops: an edge with `enable = 1` arriving while the channel is in PENDING or HOLDOFF is dropped. `drop_cnt` adds the number of such channels in that cycle and saturates at 0xFFFF. Edges while `enable = 0` are ignored and not counted.
- `drop_clr` sets `drop_cnt` to the current cycle's drop count. It does not force zero.
- Output register load condition: `~rd_req_valid | rd_req_ready`.
- When the load condition is true:
  - Select the first PENDING channel scanning upward, circularly, from `last + 1`.
  - Load `rd_req_chan` and `rd_req_ts` and assert `rd_req_valid`. That load is the grant.
  - Set `last` to the selected channel.
  - If no channel is pending, deassert `rd_req_valid`.
- While `valid & ~ready`, `rd_req_chan` and `rd_req_ts` hold stable.
- `last` resets to N_CHANNELS-1, so channel 0 has first priority after reset.
- `pending[i]` is high only in the PENDING state. A channel already loaded into the output register is in HOLDOFF and cannot be reselected.
- Lowering `enable` does not flush anything: pending channels still drain and holdoffs still run.

## Timing
- Reset values: `rd_req_valid` = 0, `rd_req_chan` = 0, `rd_req_ts` = 0, `pending` = 0, `drop_cnt` = 0. All channels start in IDLE with `hcnt` = 0.
- Latency, with `local_coinc[i]` first high at clock edge n and the output free:
  - `pending[i]` is high after edge n+1.
  - `rd_req_valid` is high after edge n+2.
  - `rd_req_ts` equals the value of `ltc` at edge n.
- Throughput: one request per cycle when `rd_req_ready` is held high.
- Simultaneous edges on k channels are all captured. They are granted on k consecutive cycles in round-robin order, each carrying its own timestamp.
- A grant and a new edge on the same channel in the same cycle: the edge is dropped and counted.
- Reset asserted mid-operation clears all state immediately. Requests in flight are lost.

## Structure
- Shared package `lc_readout_pkg`:
  - channel state localparams `ST_IDLE`, `ST_PENDING`, `ST_HOLDOFF` (2 bits)
  - default `TS_WIDTH`
  - `DROP_CNT_MAX`
- One sub-module: `lc_chan_holdoff`, instantiated per channel through generate. It contains the edge detect, state, `hcnt` and `ts` registers. It exposes `pending`, `drop`, `ts` and a `grant` input.
- The top level holds the round-robin selector, output register and drop counter.

## Test plan
- Single edge on ch 5 with `ltc` = 1000 at that edge, `ready` = 1:
  - `rd_req_valid` is asserted 2 cycles later with chan = 5, ts = 1000.
  - Valid stays high for exactly 1 cycle.
- Edges on ch 0, 3 and 23 in the same cycle, `ready` = 1:
  - Three consecutive requests in the order 0, 3, 23.
  - Repeat after holdoff: the order continues from `last` = 23, giving 0, 3, 23 again.
- Backpressure:
  - `ready` = 0 for 10 cycles with ch 2 pending: chan and ts hold stable.
  - Ch 7 becomes pending meanwhile: it is emitted the cycle after the ch 2 handshake.
- Holdoff = 4:
  - A second edge on ch 1 four cycles after its grant is dropped and `drop_cnt` = 1.
  - An edge arriving 6 cycles after the grant is captured.
- Holdoff = 0:
  - The channel is back in IDLE 1 cycle after grant.
  - An edge at grant+1 is counted as dropped; an edge at grant+2 is captured.
- Boundary conditions:
  - `enable` = 0 with edges present: no requests and `drop_cnt` unchanged.
  - Preload `drop_cnt` near 0xFFFF: it saturates.
  - `drop_clr` clears it.
  - `rst_n` pulsed mid-burst: all outputs return to their reset values asynchronously.
